// File: rtl/projection_bbox.sv
// Per-frame column/row foreground projections, thresholded into up to MAX_SEG segments per axis.
// Optional: define PROJ_MIN_LEN_EN to discard segments shorter than MIN_SEG_LEN.
module projection_bbox #(
  parameter int IMG_WIDTH      = 1024,
  parameter int IMG_HEIGHT     = 768,
  parameter int IMG_WIDTH_DATA = 24,
  parameter int CNT_WIDTH      = 12,
  parameter int H_THRESH       = 1,
  parameter int V_THRESH       = 1,
  parameter int MAX_SEG        = 4,
  parameter int MIN_SEG_LEN    = 8,
  parameter int FG_BLACK       = 1
) (
  input  logic                      pixelclk,
  input  logic                      reset,
  input  logic [IMG_WIDTH_DATA-1:0] i_binary,
  input  logic                      i_hs,
  input  logic                      i_vs,
  input  logic                      i_de,
  input  logic [11:0]               i_hcount,
  input  logic [11:0]               i_vcount,
  output logic [MAX_SEG*12-1:0]     o_h_start,
  output logic [MAX_SEG*12-1:0]     o_h_end,
  output logic [MAX_SEG*12-1:0]     o_v_start,
  output logic [MAX_SEG*12-1:0]     o_v_end,
  output logic [3:0]                o_h_num,
  output logic [3:0]                o_v_num,
  output logic                      o_h_ovf,
  output logic                      o_v_ovf,
  output logic                      o_valid
);

  localparam int CAW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RAW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int DEPTH = (IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT;
  localparam logic [12:0]          W_LIM    = 13'(IMG_WIDTH);
  localparam logic [12:0]          H_LIM    = 13'(IMG_HEIGHT);
  localparam logic [12:0]          CLR_LAST = 13'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] H_TH     = CNT_WIDTH'(H_THRESH);
  localparam logic [CNT_WIDTH-1:0] V_TH     = CNT_WIDTH'(V_THRESH);
  localparam logic [3:0]           SEG_LIM  = 4'(MAX_SEG);

  typedef enum logic [2:0] {S_CLEAR, S_WAIT, S_ACCUM, S_SCAN_H, S_SCAN_V, S_DONE} state_t;
  state_t state, state_n;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef PROJ_MIN_LEN_EN
  function automatic logic seg_keep(input logic [11:0] s, input logic [11:0] e);
    logic [12:0] len;
    len = {1'b0, e} - {1'b0, s} + 13'd1;
    return len >= 13'(MIN_SEG_LEN);
  endfunction
`else
  localparam int unused_min_len = MIN_SEG_LEN;
`endif

  logic                 vs_d, de_d, vs_rise, vs_fall;
  logic [12:0]          clr_cnt, scan_cnt;
  logic                 pix_fg, in_range, acc_pix;
  logic [CNT_WIDTH-1:0] col_ram [2**CAW];
  logic [CNT_WIDTH-1:0] row_ram [2**RAW];
  logic [CNT_WIDTH-1:0] col_rd, row_rd, wdata_p2, row_cnt;
  logic [CAW-1:0]       col_raddr, addr_p1, addr_p2;
  logic                 vld_p1, vld_p2;
  logic [RAW-1:0]       last_v;
  logic                 last_v_ok, row_wr;
  logic                 scan_on, is_h, fg, last, in_seg, close_vld, keep;
  logic [11:0]          pos, seg_start, close_start, close_end;
  logic [MAX_SEG*12-1:0] h_start_sh, h_end_sh, v_start_sh, v_end_sh;
  logic [3:0]           h_num_sh, v_num_sh;
  logic                 h_ovf_sh, v_ovf_sh;
  logic                 unused_hs;

  assign unused_hs = i_hs;
  assign vs_rise   = i_vs & ~vs_d;
  assign vs_fall   = ~i_vs & vs_d;
  assign pix_fg    = (FG_BLACK != 0) ? (i_binary == '0) : (i_binary != '0);
  assign in_range  = ({1'b0, i_hcount} < W_LIM) && ({1'b0, i_vcount} < H_LIM);
  assign acc_pix   = (state == S_ACCUM) && i_de && in_range && pix_fg;
  assign row_wr    = (state == S_ACCUM) && de_d && !i_de && last_v_ok;
  assign col_raddr = (state == S_SCAN_H) ? CAW'(scan_cnt) : CAW'(i_hcount);

  always_comb begin
    state_n = state;
    case (state)
      S_CLEAR:  if (clr_cnt == CLR_LAST) state_n = S_WAIT;
      S_WAIT:   if (vs_fall) state_n = S_ACCUM;
      S_ACCUM:  if (vs_rise) state_n = S_SCAN_H;
      S_SCAN_H: if (scan_cnt == W_LIM) state_n = S_SCAN_V;
      S_SCAN_V: if (scan_cnt == H_LIM) state_n = S_DONE;
      S_DONE:   state_n = S_CLEAR;
      default:  state_n = S_CLEAR;
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state     <= S_CLEAR;
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
      clr_cnt   <= '0;
      scan_cnt  <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      row_cnt   <= '0;
      last_v_ok <= 1'b0;
    end else begin
      state    <= state_n;
      vs_d     <= i_vs;
      de_d     <= i_de;
      clr_cnt  <= (state == S_CLEAR) ? clr_cnt + 13'd1 : '0;
      scan_cnt <= ((state == S_SCAN_H || state == S_SCAN_V) && state_n == state) ? scan_cnt + 13'd1 : '0;
      vld_p1   <= acc_pix;
      vld_p2   <= vld_p1;
      if (state != S_ACCUM || row_wr) row_cnt <= '0;
      else if (acc_pix)               row_cnt <= sat_inc(row_cnt);
      if (i_de) last_v_ok <= ({1'b0, i_vcount} < H_LIM);
    end
  end

  // Stage p0 -> p1: column bin read in flight; p1 -> p2: saturated increment awaiting write-back
  always_ff @(posedge pixelclk) begin
    addr_p1  <= CAW'(i_hcount);
    addr_p2  <= addr_p1;
    wdata_p2 <= sat_inc(col_rd);
    if (i_de) last_v <= RAW'(i_vcount);
  end

  always_ff @(posedge pixelclk) begin
    col_rd <= col_ram[col_raddr];
    if (state == S_CLEAR) col_ram[CAW'(clr_cnt)] <= '0;
    else if (vld_p2)      col_ram[addr_p2] <= wdata_p2;
  end

  always_ff @(posedge pixelclk) begin
    row_rd <= row_ram[RAW'(scan_cnt)];
    if (state == S_CLEAR) row_ram[RAW'(clr_cnt)] <= '0;
    else if (row_wr)      row_ram[last_v] <= row_cnt;
  end

  // Scan: bin for index scan_cnt-1 arrives one cycle after its address was issued
  assign is_h    = (state == S_SCAN_H);
  assign scan_on = (is_h || state == S_SCAN_V) && (scan_cnt != 13'd0);
  assign pos     = 12'(scan_cnt - 13'd1);
  assign fg      = is_h ? (col_rd >= H_TH) : (row_rd >= V_TH);
  assign last    = (scan_cnt == (is_h ? W_LIM : H_LIM));

  always_comb begin
    close_vld   = 1'b0;
    close_start = seg_start;
    close_end   = pos;
    if (scan_on) begin
      if (fg && !in_seg) begin
        close_start = pos;
        close_vld   = last;
      end else if (fg && in_seg) begin
        close_vld   = last;
      end else if (!fg && in_seg) begin
        close_vld   = 1'b1;
        close_end   = pos - 12'd1;
      end
    end
`ifdef PROJ_MIN_LEN_EN
    keep = seg_keep(close_start, close_end);
`else
    keep = 1'b1;
`endif
  end

  always_ff @(posedge pixelclk) begin
    if (reset || state == S_CLEAR) begin
      in_seg     <= 1'b0;
      seg_start  <= '0;
      h_start_sh <= '0;
      h_end_sh   <= '0;
      v_start_sh <= '0;
      v_end_sh   <= '0;
      h_num_sh   <= '0;
      v_num_sh   <= '0;
      h_ovf_sh   <= 1'b0;
      v_ovf_sh   <= 1'b0;
    end else if (scan_on) begin
      in_seg <= fg && !last;
      if (fg && !in_seg) seg_start <= pos;
      if (close_vld && keep) begin
        if (is_h) begin
          if (h_num_sh < SEG_LIM) begin
            h_start_sh[int'(h_num_sh)*12 +: 12] <= close_start;
            h_end_sh[int'(h_num_sh)*12 +: 12]   <= close_end;
            h_num_sh <= h_num_sh + 4'd1;
          end else begin
            h_ovf_sh <= 1'b1;
          end
        end else begin
          if (v_num_sh < SEG_LIM) begin
            v_start_sh[int'(v_num_sh)*12 +: 12] <= close_start;
            v_end_sh[int'(v_num_sh)*12 +: 12]   <= close_end;
            v_num_sh <= v_num_sh + 4'd1;
          end else begin
            v_ovf_sh <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      o_h_start <= '0;
      o_h_end   <= '0;
      o_v_start <= '0;
      o_v_end   <= '0;
      o_h_num   <= '0;
      o_v_num   <= '0;
      o_h_ovf   <= 1'b0;
      o_v_ovf   <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        o_h_start <= h_start_sh;
        o_h_end   <= h_end_sh;
        o_v_start <= v_start_sh;
        o_v_end   <= v_end_sh;
        o_h_num   <= h_num_sh;
        o_v_num   <= v_num_sh;
        o_h_ovf   <= h_ovf_sh;
        o_v_ovf   <= v_ovf_sh;
      end
    end
  end

endmodule

// File: tb/tb_projection_bbox.sv
// Testbench for projection_bbox: directed and random frames on a 64x48 image against a run-list model.
module tb_projection_bbox;
  localparam int W = 64, H = 48, MS = 4, HT = 3, VT = 2, MINL = 8;

  logic              pixelclk = 1'b0;
  logic              reset = 1'b1;
  logic [23:0]       i_binary = 24'hFFFFFF;
  logic              i_hs = 1'b0, i_vs = 1'b1, i_de = 1'b0;
  logic [11:0]       i_hcount = '0, i_vcount = '0;
  logic [MS*12-1:0]  o_h_start, o_h_end, o_v_start, o_v_end;
  logic [3:0]        o_h_num, o_v_num;
  logic              o_h_ovf, o_v_ovf, o_valid;

  int tests = 0;
  int fails = 0;
  bit img [H][W];
  logic [MS*12-1:0] e_hs, e_he, e_vs, e_ve;
  logic [3:0]       e_hn, e_vn;
  logic             e_ho, e_vo;

  projection_bbox #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .IMG_WIDTH_DATA(24), .CNT_WIDTH(12),
    .H_THRESH(HT), .V_THRESH(VT), .MAX_SEG(MS), .MIN_SEG_LEN(MINL), .FG_BLACK(1)
  ) dut (
    .pixelclk(pixelclk), .reset(reset), .i_binary(i_binary),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_hcount(i_hcount), .i_vcount(i_vcount),
    .o_h_start(o_h_start), .o_h_end(o_h_end), .o_v_start(o_v_start), .o_v_end(o_v_end),
    .o_h_num(o_h_num), .o_v_num(o_v_num), .o_h_ovf(o_h_ovf), .o_v_ovf(o_v_ovf),
    .o_valid(o_valid)
  );

  always #5 pixelclk = ~pixelclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic clear_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 1'b0;
  endtask

  task automatic add_rect(input int c0, input int c1, input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) img[r][c] = 1'b1;
  endtask

  // Runs of above-threshold bins, in order; short runs dropped when the length filter is built in
  task automatic segs(input int prof [64], input int n, input int thr,
                      output logic [MS*12-1:0] st, output logic [MS*12-1:0] en,
                      output logic [3:0] num, output logic ovf);
    int q_s[$];
    int q_e[$];
    int c = 0;
    int s, e;
    st = '0; en = '0;
    while (c < n) begin
      if (prof[c] >= thr) begin
        s = c;
        while (c < n && prof[c] >= thr) c++;
        e = c - 1;
`ifdef PROJ_MIN_LEN_EN
        if (e - s + 1 >= MINL) begin q_s.push_back(s); q_e.push_back(e); end
`else
        q_s.push_back(s); q_e.push_back(e);
`endif
      end else begin
        c++;
      end
    end
    ovf = (q_s.size() > MS);
    num = 4'((q_s.size() > MS) ? MS : q_s.size());
    for (int k = 0; k < int'(num); k++) begin
      st[k*12 +: 12] = 12'(q_s[k]);
      en[k*12 +: 12] = 12'(q_e[k]);
    end
  endtask

  task automatic model();
    int colp [64];
    int rowp [64];
    for (int i = 0; i < 64; i++) begin colp[i] = 0; rowp[i] = 0; end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (img[r][c]) begin colp[c]++; rowp[r]++; end
    segs(colp, W, HT, e_hs, e_he, e_hn, e_ho);
    segs(rowp, H, VT, e_vs, e_ve, e_vn, e_vo);
  endtask

  task automatic send_frame();
    repeat (90) step();
    i_vs = 1'b0;
    repeat (4) step();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        i_de = 1'b1;
        i_hcount = 12'(c);
        i_vcount = 12'(r);
        i_binary = img[r][c] ? 24'h000000 : 24'hFFFFFF;
        step();
      end
      i_de = 1'b0;
      i_binary = 24'hFFFFFF;
      i_hs = 1'b1; step(); step();
      i_hs = 1'b0; step(); step();
    end
    repeat (4) step();
    i_vs = 1'b1;
    step();
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    @(negedge pixelclk);
    while (o_valid !== 1'b1 && n < 2000) begin
      @(negedge pixelclk);
      n++;
    end
    check({tag, "_valid"},   64'(o_valid),   64'(1));
    check({tag, "_h_num"},   64'(o_h_num),   64'(e_hn));
    check({tag, "_h_ovf"},   64'(o_h_ovf),   64'(e_ho));
    check({tag, "_h_start"}, 64'(o_h_start), 64'(e_hs));
    check({tag, "_h_end"},   64'(o_h_end),   64'(e_he));
    check({tag, "_v_num"},   64'(o_v_num),   64'(e_vn));
    check({tag, "_v_ovf"},   64'(o_v_ovf),   64'(e_vo));
    check({tag, "_v_start"}, 64'(o_v_start), 64'(e_vs));
    check({tag, "_v_end"},   64'(o_v_end),   64'(e_ve));
    @(negedge pixelclk);
    check({tag, "_pulse"},   64'(o_valid),   64'(0));
    repeat (5) @(negedge pixelclk);
    check({tag, "_hold_h"},  64'(o_h_start), 64'(e_hs));
    check({tag, "_hold_v"},  64'(o_v_end),   64'(e_ve));
  endtask

  initial begin
    int nr, c0, c1, r0, r1;
    logic seen;

    repeat (3) step();
    reset = 1'b0;
    @(negedge pixelclk);
    check("rst_flags", 64'({o_h_num, o_v_num, o_h_ovf, o_v_ovf, o_valid}), 64'(0));
    check("rst_h", 64'(o_h_start | o_h_end), 64'(0));
    check("rst_v", 64'(o_v_start | o_v_end), 64'(0));

    clear_img(); add_rect(10, 20, 5, 9);
    model(); send_frame(); wait_result("single");
`ifndef PROJ_MIN_LEN_EN
    check("single_plan_h", 64'({o_h_num, o_h_start[11:0], o_h_end[11:0]}), {36'd0, 4'd1, 12'd10, 12'd20});
    check("single_plan_v", 64'({o_v_num, o_v_start[11:0], o_v_end[11:0]}), {36'd0, 4'd1, 12'd5, 12'd9});
`endif

    clear_img(); add_rect(2, 4, 10, 20); add_rect(20, 30, 10, 20); add_rect(50, 63, 10, 20);
    model(); send_frame(); wait_result("three");
`ifndef PROJ_MIN_LEN_EN
    check("three_plan", 64'({o_h_num, o_h_ovf, o_h_end[35:24]}), {47'd0, 4'd3, 1'b0, 12'd63});
`endif

    clear_img();
    for (int k = 1; k <= 6; k++) add_rect(5 * k, 5 * k, 0, 5);
    model(); send_frame(); wait_result("ovf");
`ifndef PROJ_MIN_LEN_EN
    check("ovf_plan", 64'({o_h_num, o_h_ovf, o_h_start[47:36]}), {47'd0, 4'd4, 1'b1, 12'd20});
`endif

    clear_img(); add_rect(7, 7, 0, 1); add_rect(8, 8, 0, 2);
    model(); send_frame(); wait_result("thresh");
`ifndef PROJ_MIN_LEN_EN
    check("thresh_plan", 64'({o_h_num, o_h_start[11:0], o_h_end[11:0]}), {36'd0, 4'd1, 12'd8, 12'd8});
`endif

    clear_img(); add_rect(0, 3, 3, 12); add_rect(10, 25, 3, 12);
    model(); send_frame(); wait_result("minlen");
`ifdef PROJ_MIN_LEN_EN
    check("minlen_plan", 64'({o_h_num, o_h_start[11:0], o_h_end[11:0]}), {36'd0, 4'd1, 12'd10, 12'd25});
`else
    check("minlen_plan", 64'(o_h_num), 64'(2));
`endif

    // Reset while the column scan is running
    clear_img(); add_rect(40, 50, 30, 40);
    send_frame();
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge pixelclk);
    check("midrst_flags", 64'({o_h_num, o_v_num, o_h_ovf, o_v_ovf, o_valid}), 64'(0));
    check("midrst_h", 64'(o_h_start | o_h_end), 64'(0));
    check("midrst_v", 64'(o_v_start | o_v_end), 64'(0));
    seen = 1'b0;
    repeat (400) begin
      @(negedge pixelclk);
      seen = seen | o_valid;
    end
    check("midrst_no_valid", 64'(seen), 64'(0));
    clear_img(); add_rect(12, 30, 8, 22);
    model(); send_frame(); wait_result("after_rst");

    for (int f = 0; f < 4; f++) begin
      clear_img();
      nr = int'($urandom_range(5, 1));
      for (int k = 0; k < nr; k++) begin
        c0 = int'($urandom_range(W - 1, 0));
        c1 = c0 + int'($urandom_range(14, 0));
        if (c1 > W - 1) c1 = W - 1;
        r0 = int'($urandom_range(H - 1, 0));
        r1 = r0 + int'($urandom_range(12, 0));
        if (r1 > H - 1) r1 = H - 1;
        add_rect(c0, c1, r0, r1);
      end
      model(); send_frame(); wait_result($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/projection_bbox.md
# projection_bbox

Multi-object projection locator for the recognition pipeline. Accumulates per-column and per-row foreground pixel counts over one video frame and thresholds both projections. It then extracts up to MAX_SEG foreground segments per axis, giving start/end coordinates, and publishes them with a one-cycle valid strobe. It sits after binarisation and feeds box overlay / character segmentation.

## Interface
- IMG_WIDTH, 1024: active columns; pixels with i_hcount ≥ IMG_WIDTH ignored.
- IMG_HEIGHT, 768: active rows; pixels with i_vcount ≥ IMG_HEIGHT ignored.
- IMG_WIDTH_DATA, 24: pixel width of i_binary.
- CNT_WIDTH, 12: width of each histogram bin; bins saturate at 2^CNT_WIDTH−1.
- H_THRESH, 1: column is foreground when count ≥ H_THRESH.
- V_THRESH, 1: row is foreground when count ≥ V_THRESH.
- MAX_SEG, 4: segments recorded per axis (1..8).
- MIN_SEG_LEN, 8: minimum segment length, used only with PROJ_MIN_LEN_EN.
- FG_BLACK, 1: 1 = pixel 0 is foreground; 0 = any nonzero pixel is foreground.
- pixelclk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- i_binary  in  IMG_WIDTH_DATA  binarised pixel, all bits equal.
- i_hs, i_vs, i_de  in  1  syncs (active-high) and data enable.
- i_hcount, i_vcount  in  12  pixel coordinates, valid with i_de.
- o_h_start, o_h_end  out  MAX_SEG*12  column segment bounds, segment k at bits [12k+11:12k].
- o_v_start, o_v_end  out  MAX_SEG*12  row segment bounds.
- o_h_num, o_v_num  out  4  valid segment count per axis (0..MAX_SEG).
- o_h_ovf, o_v_ovf  out  1  more segments found than MAX_SEG.
- o_valid  out  1  one-cycle strobe: result set updated.

## Operation
- States: CLEAR → WAIT → ACCUM → SCAN_H → SCAN_V → DONE → CLEAR.
- **CLEAR:** zero both bin RAMs, one address per cycle for max(IMG_WIDTH, IMG_HEIGHT) cycles.
- **WAIT:** wait for the i_vs falling edge.
- **ACCUM:** runs until the next i_vs rising edge.
  - Column bins: read-modify-write per foreground pixel (i_de=1, in range), +1 with saturation.
  - Row counter: increments per foreground pixel. On the i_de falling edge, written to row bin [i_vcount of last pixel], then cleared.
- **SCAN_H:** sweep columns 0..IMG_WIDTH−1 and set fg = bin ≥ H_THRESH.
  - 0→1 at column c opens a segment with start c.
  - 1→0 at column c closes it with end c−1.
  - fg=1 at the last column closes with end IMG_WIDTH−1.
  - Closed segments fill slots 0..MAX_SEG−1 in order. Extra segments are dropped and set the ovf flag.
- **SCAN_V:** identical over rows with V_THRESH and IMG_HEIGHT.
- **DONE:** copy shadow results to outputs, pulse o_valid for one cycle, go to CLEAR.
- Frames arriving during CLEAR/SCAN are skipped; processing resumes at the next WAIT→ACCUM.
- Unused segment slots output 0.
- Reset at any time: state CLEAR, all outputs 0, shadow registers 0, pending scan abandoned.

## Timing
- Bin RAM: 1-cycle read latency. RMW pipeline is read at t, write at t+2.
- Raster order guarantees distinct columns within 2 cycles; no forwarding required.
- Coincident row write (i_de fall) and column write use separate RAMs; no conflict.
- Scan time is IMG_WIDTH+IMG_HEIGHT+4 cycles after the i_vs rising edge.
- o_valid is asserted exactly once per processed frame.
- Outputs change only in the o_valid cycle and hold until the next one.
- i_vs rising edge during WAIT: ignored.
- i_vs edge during SCAN: ignored.

## Configuration
- PROJ_MIN_LEN_EN defined: a closed segment with (end−start+1) < MIN_SEG_LEN is discarded. It does not occupy a slot and does not count toward overflow.
- PROJ_MIN_LEN_EN undefined: every segment of length ≥1 is recorded; MIN_SEG_LEN is unused.

## Test plan
- **Single box:** 64×48 frame (IMG_WIDTH=64, IMG_HEIGHT=48), one black rectangle at cols 10..20, rows 5..9. Required: o_h_num=1, h seg0=(10,20), o_v_num=1, v seg0=(5,9), one o_valid.
- **Three boxes** at cols 2..4, 20..30, 50..63 (last touches edge). Required: o_h_num=3, segments (2,4), (20,30), (50,63), o_h_ovf=0.
- **Overflow:** MAX_SEG=4, six 1-pixel-wide columns at 5, 10, .., 30. Required: o_h_num=4, segments 5..20, o_h_ovf=1.
- **Threshold:** H_THRESH=3, column 7 with 2 foreground pixels and column 8 with 3. Required: only segment (8,8).
- **PROJ_MIN_LEN_EN**, MIN_SEG_LEN=8: boxes at cols 0..3 and 10..25. Required: o_h_num=1, segment (10,25). Without the macro: o_h_num=2.
- **Reset mid-SCAN_H:** assert reset for 1 cycle. Required: all outputs 0 next cycle, no o_valid for that frame, correct result on the following processed frame.
